// File: rtl/qos_pkg.sv
// Shared types and sizes for the QoS transmit scheduler.
package qos_pkg;

  localparam int NUM_Q   = 4;
  localparam int DEPTH_W = 3;
  localparam int PAY_W   = 2;

  typedef logic [1:0] qclass_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    ISSUE = 2'd2
  } sched_state_t;

endpackage

// File: rtl/qos_tick_gen.sv
// Free-running divider: counts 0..TICK_DIV-1 and flags the last count,
// so the cycle's closing edge is the wrap edge.
module qos_tick_gen #(
  parameter int unsigned TICK_DIV = 150000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Wrap counter, independent of scheduler state and enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                    r_cnt <= r_cnt + CW'(1);
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/qos_tx_scheduler.sv
// Four-class transmit scheduler: one dequeue per transmit tick, chosen by
// starvation guard (optional), urgent-depth override, then weighted round
// robin. Optional feature macro: QOS_AGING_EN (per-class age counters that
// force a class which has been passed over AGE_LIMIT times; ages advance
// once per tick at the arbitration that tick triggers).
module qos_tx_scheduler
  import qos_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 150000000,
  parameter int unsigned W0        = 1,
  parameter int unsigned W1        = 2,
  parameter int unsigned W2        = 3,
  parameter int unsigned W3        = 4,
  parameter int unsigned URGENT_TH = 5,
  parameter int unsigned AGE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [11:0] depth,
  output logic        deq_valid,
  output logic [1:0]  deq_sel,
  input  logic        deq_ack,
  input  logic [1:0]  deq_data,
  output logic [3:0]  read,
  output logic        tx_pulse,
  output logic [7:0]  tx_count,
  output logic        busy
);

  localparam logic [3:0] WGT [NUM_Q] = '{4'(W0), 4'(W1), 4'(W2), 4'(W3)};
  localparam logic [3:0] URG = 4'(URGENT_TH);

  sched_state_t          r_state, w_next;
  logic                  w_tick, r_tick_pend;
  qclass_t               r_sel;
  logic [3:0]            r_read;
  logic                  r_tx_pulse;
  logic [7:0]            r_tx_count;
  logic [3:0]            r_credit [NUM_Q];
  logic [3:0]            w_base   [NUM_Q];
  logic [DEPTH_W-1:0]    w_depth  [NUM_Q];
  logic [NUM_Q-1:0]      w_nonempty;
  logic                  w_any, w_urg_hit, w_wrr_hit, w_reload;
  qclass_t               w_top_sel, w_urg_sel, w_wrr_sel, w_grant;
  logic                  w_go, w_done;

  qos_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  // Per-level candidates: highest non-empty, highest urgent, highest with credit.
  always_comb begin
    w_any      = 1'b0;
    w_urg_hit  = 1'b0;
    w_wrr_hit  = 1'b0;
    w_top_sel  = '0;
    w_urg_sel  = '0;
    w_wrr_sel  = '0;
    w_nonempty = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      w_depth[i]    = depth[DEPTH_W*i +: DEPTH_W];
      w_nonempty[i] = (w_depth[i] != '0);
      if (w_nonempty[i]) begin
        w_any     = 1'b1;
        w_top_sel = qclass_t'(i);
      end
      if (w_nonempty[i] && ({1'b0, w_depth[i]} >= URG)) begin
        w_urg_hit = 1'b1;
        w_urg_sel = qclass_t'(i);
      end
      if (w_nonempty[i] && (r_credit[i] != 4'd0)) begin
        w_wrr_hit = 1'b1;
        w_wrr_sel = qclass_t'(i);
      end
    end
  end

`ifdef QOS_AGING_EN
  localparam logic [3:0] AGE_MAX = 4'(AGE_LIMIT);
  logic [3:0] r_age [NUM_Q];
  logic       w_age_hit;
  qclass_t    w_age_sel;

  // Starvation candidate: lowest-numbered class whose age has saturated.
  always_comb begin
    w_age_hit = 1'b0;
    w_age_sel = '0;
    for (int i = NUM_Q - 1; i >= 0; i--) begin
      if (w_nonempty[i] && (r_age[i] == AGE_MAX)) begin
        w_age_hit = 1'b1;
        w_age_sel = qclass_t'(i);
      end
    end
  end

  // Ages count arbitrations lost while backlogged; empty or granted clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_Q; i++) r_age[i] <= 4'd0;
    end else begin
      for (int i = 0; i < NUM_Q; i++) begin
        if (!w_nonempty[i]) begin
          r_age[i] <= 4'd0;
        end else if (r_state == ARB) begin
          if (qclass_t'(i) == w_grant) r_age[i] <= 4'd0;
          else if (r_age[i] != AGE_MAX) r_age[i] <= r_age[i] + 4'd1;
        end
      end
    end
  end
`else
  logic w_unused_age;
  assign w_unused_age = ^(4'(AGE_LIMIT));
`endif

  // Final grant by level priority; credit reload only when WRR decides.
  always_comb begin
    w_grant  = w_wrr_hit ? w_wrr_sel : w_top_sel;
    w_reload = w_any && !w_wrr_hit;
    if (w_urg_hit) begin
      w_grant  = w_urg_sel;
      w_reload = 1'b0;
    end
`ifdef QOS_AGING_EN
    if (w_age_hit) begin
      w_grant  = w_age_sel;
      w_reload = 1'b0;
    end
`endif
    for (int i = 0; i < NUM_Q; i++) begin
      w_base[i] = w_reload ? WGT[i] : r_credit[i];
    end
  end

  // Credits: optional reload, then charge the granted class once per grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_Q; i++) r_credit[i] <= WGT[i];
    end else if ((r_state == ARB) && w_any) begin
      for (int i = 0; i < NUM_Q; i++) begin
        if ((qclass_t'(i) == w_grant) && (w_base[i] != 4'd0))
          r_credit[i] <= w_base[i] - 4'd1;
        else
          r_credit[i] <= w_base[i];
      end
    end
  end

  assign w_go   = (r_state == IDLE) && r_tick_pend && enable;
  assign w_done = (r_state == ISSUE) && deq_ack;

  // Next state: tick starts arbitration; ack or a drained queue ends ISSUE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_go) w_next = ARB;
      ARB:     w_next = w_any ? ISSUE : IDLE;
      ISSUE:   if (deq_ack || (w_depth[r_sel] == '0)) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register and pending-tick flag (extra ticks merge into one).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_tick_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_go)        r_tick_pend <= 1'b0;
      else if (w_tick) r_tick_pend <= 1'b1;
    end
  end

  // Selected class is latched in ARB and held through ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_sel <= '0;
    else if ((r_state == ARB) && w_any) r_sel <= w_grant;
  end

  // Transmission record: payload tagged with class, strobe and counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_read     <= '0;
      r_tx_pulse <= 1'b0;
      r_tx_count <= '0;
    end else begin
      r_tx_pulse <= w_done;
      if (w_done) begin
        r_read     <= {r_sel, deq_data};
        r_tx_count <= r_tx_count + 8'd1;
      end
    end
  end

  assign deq_valid = (r_state == ISSUE);
  assign deq_sel   = r_sel;
  assign busy      = (r_state != IDLE);
  assign read      = r_read;
  assign tx_pulse  = r_tx_pulse;
  assign tx_count  = r_tx_count;

endmodule

// File: tb/tb_qos_tx_scheduler.sv
// Directed bench for qos_tx_scheduler (TICK_DIV=4, URGENT_TH=5, AGE_LIMIT=2).
module tb_qos_tx_scheduler;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [11:0] depth;
  logic        deq_valid;
  logic [1:0]  deq_sel;
  logic        deq_ack;
  logic [1:0]  deq_data;
  logic [3:0]  read;
  logic        tx_pulse;
  logic [7:0]  tx_count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  qos_tx_scheduler #(
    .TICK_DIV  (4),
    .W0        (1),
    .W1        (2),
    .W2        (3),
    .W3        (4),
    .URGENT_TH (5),
    .AGE_LIMIT (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .depth     (depth),
    .deq_valid (deq_valid),
    .deq_sel   (deq_sel),
    .deq_ack   (deq_ack),
    .deq_data  (deq_data),
    .read      (read),
    .tx_pulse  (tx_pulse),
    .tx_count  (tx_count),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int max);
    int n;
    n = 0;
    while (!deq_valid && n < max) begin
      step();
      n++;
    end
    check(tag, 32'(deq_valid), 32'd1);
  endtask

  task automatic wait_pulse(input string tag, input int max);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!tx_pulse && n < max);
    check(tag, 32'(tx_pulse), 32'd1);
  endtask

  initial begin
    logic       seen;
    logic [1:0] wrr_seq [10];
    logic [1:0] age_seq [3];
    wrr_seq = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
    age_seq = '{2'd3, 2'd3, 2'd0};

    rst      = 1'b1;
    enable   = 1'b0;
    depth    = 12'd0;
    deq_ack  = 1'b0;
    deq_data = 2'd0;

    // Reset values
    #2;
    check("rst_valid", 32'(deq_valid), 32'd0);
    check("rst_sel",   32'(deq_sel),   32'd0);
    check("rst_read",  32'(read),      32'd0);
    check("rst_pulse", 32'(tx_pulse),  32'd0);
    check("rst_count", 32'(tx_count),  32'd0);
    check("rst_busy",  32'(busy),      32'd0);

    // Urgent override: class 0 depth 5 beats class 3 depth 2; wrap at 4th edge
    @(negedge clk);
    rst    = 1'b0;
    enable = 1'b1;
    depth  = {3'd2, 3'd0, 3'd0, 3'd5};
    repeat (5) step();
    check("lat_before", 32'(deq_valid), 32'd0);
    step();
    check("lat_issue",  32'(deq_valid), 32'd1);
    check("issue_busy", 32'(busy),      32'd1);
    check("urgent_sel", 32'(deq_sel),   32'd0);

    // Ack withheld: request and class must hold steady
    for (int k = 0; k < 4; k++) begin
      step();
      check("stall_valid", 32'(deq_valid), 32'd1);
      check("stall_sel",   32'(deq_sel),   32'd0);
      check("stall_pulse", 32'(tx_pulse),  32'd0);
    end
    deq_data = 2'b11;
    deq_ack  = 1'b1;
    step();
    deq_ack  = 1'b0;
    check("tx_pulse",    32'(tx_pulse),  32'd1);
    check("tx_read",     32'(read),      32'h3);
    check("tx_count1",   32'(tx_count),  32'd1);
    check("tx_idle",     32'(deq_valid), 32'd0);
    step();
    check("pulse_width", 32'(tx_pulse),  32'd0);
    check("read_hold",   32'(read),      32'h3);

    // Abort: queue drains before the ack
    wait_valid("abort_wait", 10);
    check("abort_sel", 32'(deq_sel), 32'd0);
    depth = 12'd0;
    step();
    check("abort_valid", 32'(deq_valid), 32'd0);
    check("abort_pulse", 32'(tx_pulse),  32'd0);
    check("abort_count", 32'(tx_count),  32'd1);

    // All queues empty for five ticks
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (deq_valid) seen = 1'b1;
    end
    check("empty_valid", 32'(seen),     32'd0);
    check("empty_count", 32'(tx_count), 32'd1);

    // Reset while a dequeue is outstanding
    depth = {3'd4, 3'd4, 3'd4, 3'd4};
    wait_valid("mid_wait", 10);
    check("mid_sel", 32'(deq_sel), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("mid_valid", 32'(deq_valid), 32'd0);
    check("mid_busy",  32'(busy),      32'd0);
    check("mid_sel0",  32'(deq_sel),   32'd0);
    check("mid_read",  32'(read),      32'd0);
    check("mid_count", 32'(tx_count),  32'd0);
    @(negedge clk);
    rst      = 1'b0;
    deq_ack  = 1'b1;
    deq_data = 2'b01;
    repeat (5) step();
    check("post_lat_before", 32'(deq_valid), 32'd0);
    step();
    check("post_lat_issue",  32'(deq_valid), 32'd1);
    check("post_sel",        32'(deq_sel),   32'd3);

`ifndef QOS_AGING_EN
    // Weighted round robin over equal backlogs, two grants into the next round
    for (int k = 0; k < 12; k++) begin
      wait_pulse("wrr_pulse", 12);
      check("wrr_read", 32'(read), 32'({wrr_seq[k % 10], 2'b01}));
      if (k == 9) check("wrr_count10", 32'(tx_count), 32'd10);
    end
    check("wrr_count12", 32'(tx_count), 32'd12);
`else
    // Starvation guard: class 0 forced after two lost arbitrations
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    depth = {3'd6, 3'd0, 3'd0, 3'd1};
    for (int k = 0; k < 3; k++) begin
      wait_pulse("age_pulse", 12);
      check("age_class", 32'(read[3:2]), 32'(age_seq[k]));
    end
    check("age_count", 32'(tx_count), 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qos_tx_scheduler.md
# qos_tx_scheduler

Transmit scheduler for the four-class QoS packet buffers. On every transmit tick it picks one non-empty class queue, runs a dequeue handshake with the buffer block, and publishes the sent 2-bit payload tagged with its class. Selection uses three levels, highest first: an optional starvation guard, an urgent-depth override, then weighted round robin. The buffer/drop logic stays in the buffer block, which only sees `deq_valid`/`deq_sel`.

## Interface
- `TICK_DIV`, 150000000: clock cycles per transmit tick.
- `W0`..`W3`, 1/2/3/4: per-class WRR weights, 1..15. Class 3 is highest priority.
- `URGENT_TH`, 5: depth at or above which a class is urgent. Set it to 7 to disable the override.
- `AGE_LIMIT`, 8: tick count after which a starved class is forced, 1..15.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: scheduling allowed.
- `depth` in 12: `depth[3i+:3]` is the occupancy of class i, 0..6.
- `deq_valid` out 1: dequeue request.
- `deq_sel` out 2: class being dequeued.
- `deq_ack` in 1: the buffer popped the head this cycle.
- `deq_data` in 2: head payload, valid while `deq_ack` is high.
- `read` out 4: `{class, payload}` of the last transmission. Held between transmissions.
- `tx_pulse` out 1: one-cycle strobe when `read` updates.
- `tx_count` out 8: number of transmissions, wraps modulo 256.
- `busy` out 1: state is not IDLE.

## Operation
- Reset values:
  - all outputs 0;
  - state IDLE;
  - tick counter 0;
  - `tick_pend` 0;
  - `credit[i]` = Wi;
  - `age[i]` = 0.
- Tick counter:
  - counts 0..TICK_DIV-1 and wraps;
  - the wrap edge sets `tick_pend`;
  - keeps running regardless of `enable` and state;
  - ticks that arrive while `tick_pend` is already set are merged, not queued.
- State machine: IDLE, ARB, ISSUE.
  - IDLE → ARB when `tick_pend` and `enable`; clear `tick_pend` on this transition.
  - ARB runs the selection.
    - No non-empty class: return to IDLE. The tick is consumed and there is no transmission.
    - Otherwise latch the chosen class into `deq_sel` and go to ISSUE.
  - ISSUE: `deq_valid` is 1 and `deq_sel` is stable.
    - `deq_ack` sampled high: `read <= {deq_sel, deq_data}`, `tx_pulse <= 1` for one cycle, `tx_count++`, go to IDLE.
    - `depth[deq_sel] == 0` before the ack: abort to IDLE with no transmission and no counter change.
  - An ISSUE in progress completes even if `enable` falls.
- Selection order in ARB:
  1. Aging, only with `QOS_AGING_EN`: lowest-numbered class with `age == AGE_LIMIT`.
  2. Urgent: highest-numbered class with `depth >= URGENT_TH`.
  3. WRR: highest-numbered non-empty class with `credit > 0`. If every non-empty class has `credit == 0`, reload all credits to Wi and select from the reloaded values in the same cycle.
- Credit bookkeeping:
  - a grant from any of the three levels decrements the granted class's credit if it is above 0;
  - the decrement applies in ARB;
  - credits are 4 bits wide.
- Reset during ISSUE: `deq_valid` drops asynchronously and no transmission is recorded.

## Timing
- A wrap at edge E:
  - `tick_pend` is 1 after E;
  - ARB runs in the cycle after E+1;
  - `deq_valid` is 1 after edge E+2.
- If `deq_ack` is high in the first ISSUE cycle, `read`, `tx_pulse` and `tx_count` update at edge E+3.
- Minimum tick-to-transmission latency is 3 cycles. `TICK_DIV >= 4` is required.
- `tx_pulse` is exactly one cycle wide, and there are never two grants per tick.

## Configuration
- `QOS_AGING_EN` defined:
  - per-class 4-bit `age` counters advance once per tick edge while the class is non-empty and not being served;
  - they saturate at `AGE_LIMIT`;
  - they clear when the class is granted or its depth is 0;
  - aging precedes urgent in selection.
- `QOS_AGING_EN` undefined: no age registers, and selection step 1 is absent.

## Structure
- `qos_pkg` holds:
  - `NUM_Q` = 4, `DEPTH_W` = 3, `PAY_W` = 2;
  - the `qclass_t` (2-bit) typedef;
  - the `sched_state_t` enum (IDLE, ARB, ISSUE).
- Sub-module `qos_tick_gen` (parameter `TICK_DIV`): wrap counter with a one-cycle `tick` output.

## Test plan
1. **Urgent override.** TICK_DIV=4. Class 0 depth 5, class 3 depth 2. Expect the first grant `deq_sel=0`.
2. **WRR order.** URGENT_TH=7, every depth held at 4, `deq_ack` immediate. Expect a grant sequence of 3,3,3,3,2,2,2,1,1,0 that then repeats, with `tx_count=10` after 10 ticks.
3. **All empty.** All depths 0 for 5 ticks. Expect `deq_valid` never asserted and `tx_count=0`.
4. **Handshake stall and abort.**
   - Ack delayed 5 cycles: `deq_sel` stable, `read={sel,deq_data}`, `tx_pulse` one cycle.
   - Depth forced to 0 before the ack: `deq_valid` drops, `tx_count` unchanged.
5. **Aging** (`QOS_AGING_EN`, AGE_LIMIT=2). Class 3 held at 6, class 0 at 1. Expect grants 3,3,0.
6. **Reset mid-ISSUE.** Assert `rst` while `deq_valid=1`. Expect `deq_valid=0` with no clock edge, all outputs 0, and the first grant after release three cycles after the next wrap.
